// File: rtl/frame_pkg.sv
// Shared widths and limits for the CAN frame-size counter slice.
package frame_pkg;

    localparam int FRAME_SIZE_W = 10;
    localparam int STUFF_CNT_W  = 8;

    localparam int FRAME_SIZE_MAX = (1 << FRAME_SIZE_W) - 1;
    localparam int STUFF_CNT_MAX  = (1 << STUFF_CNT_W) - 1;

endpackage : frame_pkg

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] r_cnt;

    assign at_max = (r_cnt == {W{1'b1}});
    assign cnt    = r_cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/frame_size_counter.sv
// Counts non-stuff and stuff bit times of the current CAN frame, with a sticky saturation flag.
module frame_size_counter
    import frame_pkg::*;
#(
    parameter int SIZE_W  = FRAME_SIZE_W,
    parameter int STUFF_W = STUFF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sp,
    input  logic               isStuff,
    input  logic               clr,
    output logic [SIZE_W-1:0]  size,
    output logic [STUFF_W-1:0] stuff_cnt,
    output logic               sat
);

    logic w_size_inc;
    logic w_stuff_inc;
    logic w_size_at_max;
    logic w_stuff_at_max;
    logic w_sat_evt;
    logic r_sat;

    assign w_size_inc  = sp & ~isStuff;
    assign w_stuff_inc = sp & isStuff;

    sat_counter #(.W(SIZE_W)) u_size_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .inc    (w_size_inc),
        .cnt    (size),
        .at_max (w_size_at_max)
    );

    sat_counter #(.W(STUFF_W)) u_stuff_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .inc    (w_stuff_inc),
        .cnt    (stuff_cnt),
        .at_max (w_stuff_at_max)
    );

    // A saturation event is a sample arriving while its counter is already pinned at max.
    // NOTE: always_comb assigns its output on every path, so no latch can be inferred.
    always_comb begin
        w_sat_evt = 1'b0;
        if ((w_size_inc && w_size_at_max) || (w_stuff_inc && w_stuff_at_max)) begin
            w_sat_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
        end else if (clr) begin
            r_sat <= 1'b0;
        end else if (w_sat_evt) begin
            r_sat <= 1'b1;
        end
    end

    assign sat = r_sat;

endmodule : frame_size_counter

// File: tb/tb_frame_size_counter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and random traffic vs a model.
module tb_frame_size_counter;
    import frame_pkg::*;

    logic                    clk;
    logic                    reset;
    logic                    sp;
    logic                    isStuff;
    logic                    clr;
    logic [FRAME_SIZE_W-1:0] size;
    logic [STUFF_CNT_W-1:0]  stuff_cnt;
    logic                    sat;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integer counts following the frame rules.
    int m_size  = 0;
    int m_stuff = 0;
    int m_sat   = 0;

    typedef struct {
        bit sp;
        bit st;
        bit clr;
        int exp_size;
        int exp_stuff;
        int exp_sat;
    } vec_t;

    vec_t vecs[$];

    frame_size_counter dut (
        .clk       (clk),
        .reset     (reset),
        .sp        (sp),
        .isStuff   (isStuff),
        .clr       (clr),
        .size      (size),
        .stuff_cnt (stuff_cnt),
        .sat       (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_step(input bit s, input bit st, input bit c);
        if (!reset) begin
            m_size = 0; m_stuff = 0; m_sat = 0;
        end else if (c) begin
            m_size = 0; m_stuff = 0; m_sat = 0;
        end else if (s && !st) begin
            if (m_size == FRAME_SIZE_MAX) m_sat = 1;
            else m_size = m_size + 1;
        end else if (s && st) begin
            if (m_stuff == STUFF_CNT_MAX) m_sat = 1;
            else m_stuff = m_stuff + 1;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model; outputs read at edge+1.
    task automatic step(input bit s, input bit st, input bit c);
        sp = s; isStuff = st; clr = c;
        @(posedge clk);
        #1;
        model_step(s, st, c);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".size"},  int'(size),      m_size);
        check({tag, ".stuff"}, int'(stuff_cnt), m_stuff);
        check({tag, ".sat"},   int'(sat),       m_sat);
    endtask

    initial begin
        reset = 1'b0; sp = 1'b0; isStuff = 1'b0; clr = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("rst.size", int'(size), 0);
            check("rst.stuff", int'(stuff_cnt), 0);
            check("rst.sat", int'(sat), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("idle.size", int'(size), 0);
            check("idle.stuff", int'(stuff_cnt), 0);
            check("idle.sat", int'(sat), 0);
        end

        // Mixed frame, clear, resume, clear-with-sample.
        vecs.push_back('{0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 2, 0, 0});
        vecs.push_back('{1, 0, 0, 3, 0, 0});
        vecs.push_back('{1, 1, 0, 3, 1, 0});
        vecs.push_back('{1, 0, 0, 4, 1, 0});
        vecs.push_back('{1, 0, 0, 5, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 2, 0, 0});
        vecs.push_back('{1, 0, 0, 3, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 1, 0});
        foreach (vecs[i]) begin
            step(vecs[i].sp, vecs[i].st, vecs[i].clr);
            check($sformatf("vec%0d.size", i),  int'(size),      vecs[i].exp_size);
            check($sformatf("vec%0d.stuff", i), int'(stuff_cnt), vecs[i].exp_stuff);
            check($sformatf("vec%0d.sat", i),   int'(sat),       vecs[i].exp_sat);
        end

        // Size saturation.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1025; i++) step(1'b1, 1'b0, 1'b0);
        check("satsz.size", int'(size), 1023);
        check("satsz.sat", int'(sat), 1);
        step(1'b1, 1'b0, 1'b0);
        check("satsz_more.size", int'(size), 1023);
        check("satsz_more.sat", int'(sat), 1);
        step(1'b0, 1'b0, 1'b0);
        check("satsz_idle.sat", int'(sat), 1);
        step(1'b0, 1'b0, 1'b1);
        check("satsz_clr.size", int'(size), 0);
        check("satsz_clr.sat", int'(sat), 0);

        // Stuff-count saturation.
        for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 1'b0);
        check("satst.stuff", int'(stuff_cnt), 255);
        check("satst.size", int'(size), 0);
        check("satst.sat", int'(sat), 1);
        step(1'b0, 1'b0, 1'b1);
        check("satst_clr.stuff", int'(stuff_cnt), 0);
        check("satst_clr.sat", int'(sat), 0);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        check("arst_pre.size", int'(size), 7);
        #2;
        reset = 1'b0;
        #1;
        check("arst_now.size", int'(size), 0);
        check("arst_now.sat", int'(sat), 0);
        model_step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("arst_hold.size", int'(size), 0);
        #2;
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check("arst_resume.size", int'(size), 1);
        check_model("arst_model");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 40) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_frame_size_counter
